find_bkt_lvl_ctrl: RTL and testbench

//  Initiator side of the Sat Engine find-bkt-lvl / backtrack interface. On a

---
 rtl/find_bkt_lvl_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_find_bkt_lvl_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/find_bkt_lvl_ctrl.sv
// Find-backtrack-level initiator: scans the latched level-state array from the
// clamped max level downward, writes the backtrack update and returns the result.
// Build option FIND_BKT_PARALLEL_EN: single-cycle priority-encoded scan instead of
// the serial one-level-per-cycle scan (results and writes are identical).
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | waiting for start_i; result outputs held at 0
//  SCAN     | searching latched copy for deepest level with has_bkt = 0
//  WRITE    | one-cycle write strobe of levels L..lim, apply_bkt_o pulse
//  RESP     | res_valid_o held with result until res_ready_i
module find_bkt_lvl_ctrl #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic                                 busy_o,
    output logic [NUM_LVLS-1:0]                  wr_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    output logic                                 apply_bkt_o,
    output logic                                 res_valid_o,
    input  logic                                 res_ready_i,
    output logic                                 found_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]              bkt_bin_o
);

    localparam int W  = WIDTH_LVL_STATES;
    localparam int SW = WIDTH_LVL_STATES * NUM_LVLS;
    localparam int PW = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]              state_q,      state_d;
    logic [SW-1:0]           states_q,     states_d;
    logic [PW-1:0]           lim_q,        lim_d;
    logic [PW-1:0]           ptr_q,        ptr_d;
    logic [NUM_LVLS-1:0]     wr_states_q,  wr_states_d;
    logic [SW-1:0]           lvl_states_q, lvl_states_d;
    logic                    apply_q,      apply_d;
    logic                    res_valid_q,  res_valid_d;
    logic                    found_q,      found_d;
    logic [WIDTH_LVL-1:0]    bkt_lvl_q,    bkt_lvl_d;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q,    bkt_bin_d;

    logic [NUM_LVLS-1:0]     has_bkt;
    logic [PW-1:0]           lim_clamp;
    logic [PW-1:0]           tgt;
    logic                    hit;
    logic                    miss;
    logic [W-1:0]            tgt_slice;
    logic [NUM_LVLS-1:0]     wr_mask;
    logic [SW-1:0]           wr_data;

    assign lim_clamp = (max_lvl_i > WIDTH_LVL'(NUM_LVLS - 1)) ? PW'(NUM_LVLS - 1)
                                                              : max_lvl_i[PW-1:0];

    always_comb begin
        has_bkt = '0;
        for (int l = 0; l < NUM_LVLS; l++) begin
            has_bkt[l] = states_q[l*W];
        end
    end

`ifdef FIND_BKT_PARALLEL_EN
    // Ascending loop so the highest qualifying level wins; level 0 never qualifies.
    always_comb begin
        hit = 1'b0;
        tgt = '0;
        for (int l = 1; l < NUM_LVLS; l++) begin
            if ((PW'(l) <= lim_q) && !has_bkt[l]) begin
                hit = 1'b1;
                tgt = PW'(l);
            end
        end
        miss = !hit;
    end
`else
    always_comb begin
        tgt  = ptr_q;
        miss = (ptr_q == '0);
        hit  = !miss && !has_bkt[ptr_q];
    end
`endif

    always_comb begin
        tgt_slice = '0;
        wr_mask   = '0;
        wr_data   = '0;
        for (int l = 0; l < NUM_LVLS; l++) begin
            if (PW'(l) == tgt) begin
                tgt_slice = states_q[l*W +: W];
            end
        end
        for (int l = 0; l < NUM_LVLS; l++) begin
            wr_mask[l] = (PW'(l) >= tgt) && (PW'(l) <= lim_q);
            if (PW'(l) == tgt) begin
                wr_data[l*W +: W] = {tgt_slice[W-1:1], 1'b1};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        states_d     = states_q;
        lim_d        = lim_q;
        ptr_d        = ptr_q;
        wr_states_d  = '0;
        lvl_states_d = '0;
        apply_d      = 1'b0;
        res_valid_d  = res_valid_q;
        found_d      = found_q;
        bkt_lvl_d    = bkt_lvl_q;
        bkt_bin_d    = bkt_bin_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    states_d = lvl_states_i;
                    lim_d    = lim_clamp;
                    ptr_d    = lim_clamp;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hit) begin
                    state_d      = ST_WRITE;
                    ptr_d        = tgt;
                    wr_states_d  = wr_mask;
                    lvl_states_d = wr_data;
                    apply_d      = 1'b1;
                    found_d      = 1'b1;
                    bkt_lvl_d    = WIDTH_LVL'(tgt);
                    bkt_bin_d    = tgt_slice[W-1:1];
                end else if (miss) begin
                    state_d     = ST_RESP;
                    res_valid_d = 1'b1;
                    found_d     = 1'b0;
                    bkt_lvl_d   = '0;
                    bkt_bin_d   = '0;
                end else begin
                    ptr_d = ptr_q - 1'b1;
                end
            end
            ST_WRITE: begin
                state_d     = ST_RESP;
                res_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (res_ready_i) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    found_d     = 1'b0;
                    bkt_lvl_d   = '0;
                    bkt_bin_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            states_q     <= '0;
            lim_q        <= '0;
            ptr_q        <= '0;
            wr_states_q  <= '0;
            lvl_states_q <= '0;
            apply_q      <= 1'b0;
            res_valid_q  <= 1'b0;
            found_q      <= 1'b0;
            bkt_lvl_q    <= '0;
            bkt_bin_q    <= '0;
        end else begin
            state_q      <= state_d;
            states_q     <= states_d;
            lim_q        <= lim_d;
            ptr_q        <= ptr_d;
            wr_states_q  <= wr_states_d;
            lvl_states_q <= lvl_states_d;
            apply_q      <= apply_d;
            res_valid_q  <= res_valid_d;
            found_q      <= found_d;
            bkt_lvl_q    <= bkt_lvl_d;
            bkt_bin_q    <= bkt_bin_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign wr_states_o  = wr_states_q;
    assign lvl_states_o = lvl_states_q;
    assign apply_bkt_o  = apply_q;
    assign res_valid_o  = res_valid_q;
    assign found_o      = found_q;
    assign bkt_lvl_o    = bkt_lvl_q;
    assign bkt_bin_o    = bkt_bin_q;

endmodule

// File: tb/tb_find_bkt_lvl_ctrl.sv
// Scoreboard bench for find_bkt_lvl_ctrl: directed requests push expected results,
// a negedge monitor checks writes, results, handshake stability and scan length.
module tb_find_bkt_lvl_ctrl;

    localparam int N  = 8;
    localparam int WL = 16;
    localparam int WB = 10;
    localparam int W  = 11;
    localparam int SW = W * N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic [WL-1:0] max_lvl_i = '0;
    logic [SW-1:0] lvl_states_i = '0;
    logic          busy_o;
    logic [N-1:0]  wr_states_o;
    logic [SW-1:0] lvl_states_o;
    logic          apply_bkt_o;
    logic          res_valid_o;
    logic          res_ready_i = 1'b1;
    logic          found_o;
    logic [WL-1:0] bkt_lvl_o;
    logic [WB-1:0] bkt_bin_o;

    find_bkt_lvl_ctrl #(
        .NUM_LVLS(N), .WIDTH_LVL(WL), .WIDTH_BIN_ID(WB), .WIDTH_LVL_STATES(W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .max_lvl_i(max_lvl_i),
        .lvl_states_i(lvl_states_i), .busy_o(busy_o), .wr_states_o(wr_states_o),
        .lvl_states_o(lvl_states_o), .apply_bkt_o(apply_bkt_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .found_o(found_o),
        .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          found;
        logic [WL-1:0] lvl;
        logic [WB-1:0] bin;
        logic [N-1:0]  wr;
        logic [SW-1:0] data;
        int            scan;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   scan_cnt = 0;
    logic saw_wr = 1'b0;
    logic prev_valid = 1'b0;

    function automatic logic [WB-1:0] bin_of(input int l);
        return WB'(10'h155 ^ (l * 73));
    endfunction

    function automatic logic [SW-1:0] mk_states(input logic [N-1:0] hb);
        logic [SW-1:0] v;
        v = '0;
        for (int l = 0; l < N; l++) v[l*W +: W] = {bin_of(l), hb[l]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: sampled on negedge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            scan_cnt   = 0;
            saw_wr     = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (apply_bkt_o) begin
                if (q.size() == 0) begin
                    chk("wr_unexpected", 96'(apply_bkt_o), 96'(0));
                end else begin
                    chk("wr_expected", 96'(apply_bkt_o), 96'(q[0].found));
                    chk("wr_states", 96'(wr_states_o), 96'(q[0].wr));
                    chk("wr_data", 96'(lvl_states_o), 96'(q[0].data));
                end
                saw_wr = 1'b1;
            end else begin
                chk("wr_idle", 96'(wr_states_o), 96'(0));
                chk("data_idle", 96'(lvl_states_o), 96'(0));
            end
            if (busy_o && !apply_bkt_o && !res_valid_o) scan_cnt++;
            if (res_valid_o) begin
                if (q.size() == 0) begin
                    chk("res_unexpected", 96'(res_valid_o), 96'(0));
                end else begin
                    chk("found", 96'(found_o), 96'(q[0].found));
                    chk("bkt_lvl", 96'(bkt_lvl_o), 96'(q[0].lvl));
                    chk("bkt_bin", 96'(bkt_bin_o), 96'(q[0].bin));
                    if (!prev_valid) begin
                        chk("scan_cycles", 96'(scan_cnt), 96'(q[0].scan));
                        chk("write_seen", 96'(saw_wr), 96'(q[0].found));
                    end
                    if (res_ready_i) begin
                        void'(q.pop_front());
                        scan_cnt = 0;
                        saw_wr   = 1'b0;
                    end
                end
            end
            prev_valid = res_valid_o;
        end
    end

    task automatic push_exp(input logic fnd, input int l, input logic [N-1:0] wr,
                            input int scan_ser);
        exp_t e;
        e.found = fnd;
        e.lvl   = fnd ? WL'(l) : '0;
        e.bin   = fnd ? bin_of(l) : '0;
        e.wr    = fnd ? wr : '0;
        e.data  = '0;
        if (fnd) e.data[l*W +: W] = {bin_of(l), 1'b1};
`ifdef FIND_BKT_PARALLEL_EN
        e.scan = 1;
`else
        e.scan = scan_ser;
`endif
        q.push_back(e);
    endtask

    task automatic issue(input logic [WL-1:0] maxl, input logic [N-1:0] hb);
        @(posedge clk); #1;
        start_i      = 1'b1;
        max_lvl_i    = maxl;
        lvl_states_i = mk_states(hb);
        @(posedge clk); #1;
        start_i      = 1'b0;
        max_lvl_i    = 16'hFFFF;
        lvl_states_i = ~mk_states(hb);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q.size() != 0 || busy_o) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("timeout", 96'(busy_o), 96'(0));
    endtask

    task automatic do_req(input logic [WL-1:0] maxl, input logic [N-1:0] hb,
                          input logic fnd, input int l, input logic [N-1:0] wr,
                          input int scan_ser);
        push_exp(fnd, l, wr, scan_ser);
        issue(maxl, hb);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 96'(busy_o), 96'(0));
        chk("rst_valid", 96'(res_valid_o), 96'(0));
        chk("rst_apply", 96'(apply_bkt_o), 96'(0));
        chk("rst_found", 96'(found_o), 96'(0));
        chk("rst_lvl", 96'(bkt_lvl_o), 96'(0));
        rst = 1'b1;

        // Reset in the middle of SCAN aborts with no write.
        issue(16'd7, 8'hFF);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 96'(busy_o), 96'(0));
        chk("abort_wr", 96'(wr_states_o), 96'(0));
        chk("abort_apply", 96'(apply_bkt_o), 96'(0));
        chk("abort_valid", 96'(res_valid_o), 96'(0));
        @(posedge clk); #1;
        chk("abort_busy2", 96'(busy_o), 96'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Found: levels 5..1 has_bkt = 1,1,1,0,0; levels above lim ignored.
        do_req(16'd5,  8'b0011_1000, 1'b1, 2, 8'b0011_1100, 4);
        // Not found: levels 1..3 set, root clear but never a target.
        do_req(16'd3,  8'b0000_1110, 1'b0, 0, 8'h00, 4);
        // Clamp: max_lvl 12 -> lim 7, level 7 clear.
        do_req(16'd12, 8'b0111_1111, 1'b1, 7, 8'b1000_0000, 1);
        // max_lvl 0 -> not found.
        do_req(16'd0,  8'b0000_0000, 1'b0, 0, 8'h00, 1);
        // Full-depth scans.
        do_req(16'd7,  8'b1111_1110, 1'b0, 0, 8'h00, 8);
        do_req(16'd7,  8'b1111_1101, 1'b1, 1, 8'b1111_1110, 7);
        do_req(16'd9,  8'b1011_1111, 1'b1, 6, 8'b1100_0000, 2);

        // Handshake: ready low, start pulsed during RESP.
        res_ready_i = 1'b0;
        push_exp(1'b1, 2, 8'b0011_1100, 4);
        issue(16'd5, 8'b0011_1000);
        n = 0;
        while (!res_valid_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("hs_valid_timeout", 96'(res_valid_o), 96'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start_i      = (i == 0);
            max_lvl_i    = 16'd7;
            lvl_states_i = mk_states(8'b0111_1111);
            chk("hs_hold_valid", 96'(res_valid_o), 96'(1));
        end
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("hs_idle_busy", 96'(busy_o), 96'(0));
        chk("hs_idle_valid", 96'(res_valid_o), 96'(0));
        chk("hs_idle_found", 96'(found_o), 96'(0));
        chk("hs_idle_bin", 96'(bkt_bin_o), 96'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("hs_start_ignored", 96'(busy_o), 96'(0));
        chk("hs_queue_empty", 96'(q.size()), 96'(0));

        // Normal operation after handshake test.
        do_req(16'd4, 8'b0001_0110, 1'b1, 3, 8'b0001_1000, 2);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
